// File: rtl/register_byte_reader.sv
// Snapshot register reader: captures a WIDTH-bit word and streams it out one
// BYTE_WIDTH lane per valid/ready handshake, least-significant lane first.
module register_byte_reader #(
    parameter  int unsigned WIDTH      = 32,
    parameter  int unsigned BYTE_WIDTH = 8,
    localparam int unsigned NBYTES     = (WIDTH - 1) / BYTE_WIDTH + 1,
    localparam int unsigned IDX_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [WIDTH-1:0]      d_i,
    output logic                  byte_valid_o,
    input  logic                  byte_ready_i,
    output logic [BYTE_WIDTH-1:0] byte_o,
    output logic [IDX_W-1:0]      byte_idx_o,
    output logic                  byte_last_o
);

    localparam int unsigned SHADOW_W = NBYTES * BYTE_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                             state_q, state_d;
    logic [NBYTES-1:0][BYTE_WIDTH-1:0]  shadow_q, shadow_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;

    logic lane_last_c;
    logic load_hs_c;
    logic byte_hs_c;

    // State register; shadow upper pad bits are zero because d_i is zero-extended on capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state, handshakes and lane outputs
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        load_ready_o = 1'b0;
        byte_valid_o = 1'b0;
        byte_o       = '0;
        byte_idx_o   = '0;
        byte_last_o  = 1'b0;

        lane_last_c = (idx_q == IDX_W'(NBYTES - 1));

        if (state_q == SEND) begin
            byte_valid_o = 1'b1;
            byte_o       = shadow_q[idx_q];
            byte_idx_o   = idx_q;
            byte_last_o  = lane_last_c;
        end

        // Reload is offered on the final lane handshake so streams can run back-to-back
        if (rst && !flush_i) begin
            load_ready_o = (state_q == IDLE) ? 1'b1 : (byte_ready_i & lane_last_c);
        end

        load_hs_c = load_valid_i & load_ready_o;
        byte_hs_c = byte_valid_o & byte_ready_i;

        if (flush_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            if (byte_hs_c) begin
                if (lane_last_c) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            if (load_hs_c) begin
                shadow_d = SHADOW_W'(d_i);
                idx_d    = '0;
                state_d  = SEND;
            end
        end
    end

endmodule

// File: tb/tb_register_byte_reader.sv
// Randomized and directed checks of register_byte_reader against a lane-queue model.
module tb_register_byte_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        load_valid_i;
    logic        load_ready_o;
    logic [31:0] d_i;
    logic        byte_valid_o;
    logic        byte_ready_i;
    logic [7:0]  byte_o;
    logic [1:0]  byte_idx_o;
    logic        byte_last_o;

    logic        rst12;
    logic        flush12;
    logic        lv12;
    logic        lr12;
    logic [11:0] d12;
    logic        bv12;
    logic        br12;
    logic [7:0]  b12;
    logic [0:0]  idx12;
    logic        last12;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mq[$];
    logic [7:0] hs_log[$];

    always #5 clk = ~clk;

    register_byte_reader #(.WIDTH(32), .BYTE_WIDTH(8)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .d_i          (d_i),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .byte_o       (byte_o),
        .byte_idx_o   (byte_idx_o),
        .byte_last_o  (byte_last_o)
    );

    register_byte_reader #(.WIDTH(12), .BYTE_WIDTH(8)) u_dut12 (
        .clk          (clk),
        .rst          (rst12),
        .flush_i      (flush12),
        .load_valid_i (lv12),
        .load_ready_o (lr12),
        .d_i          (d12),
        .byte_valid_o (bv12),
        .byte_ready_i (br12),
        .byte_o       (b12),
        .byte_idx_o   (idx12),
        .byte_last_o  (last12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, compare against the lane queue, then advance the model
    task automatic step(input logic lv, input logic [31:0] d, input logic rdy, input logic fl);
        logic busy;
        logic exp_lr;
        @(negedge clk);
        load_valid_i = lv;
        d_i          = d;
        byte_ready_i = rdy;
        flush_i      = fl;
        #1;
        busy   = (mq.size() != 0);
        exp_lr = !fl && (!busy || (rdy && mq.size() == 1));
        check("byte_valid", 32'(byte_valid_o), 32'(busy));
        check("load_ready", 32'(load_ready_o), 32'(exp_lr));
        if (busy) begin
            check("byte", 32'(byte_o), 32'(mq[0]));
            check("idx", 32'(byte_idx_o), 32'(4 - mq.size()));
            check("last", 32'(byte_last_o), 32'(mq.size() == 1));
        end else begin
            check("idle_byte", 32'(byte_o), 32'h0);
            check("idle_last", 32'(byte_last_o), 32'h0);
        end
        if (!fl && byte_valid_o && rdy) hs_log.push_back(byte_o);
        if (fl) begin
            mq.delete();
        end else begin
            if (busy && rdy) void'(mq.pop_front());
            if (lv && exp_lr) for (int k = 0; k < 4; k++) mq.push_back(d[8*k +: 8]);
        end
    endtask

    task automatic expect_log(input string tag, input logic [63:0] bytes, input int n);
        check({tag, "_count"}, 32'(hs_log.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k < hs_log.size()) check(tag, 32'(hs_log[k]), 32'(bytes[8*(n-1-k) +: 8]));
        end
        hs_log.delete();
    endtask

    initial begin
        logic [63:0] exp_bytes;
        rst = 1'b0; flush_i = 1'b0; load_valid_i = 1'b0; d_i = '0; byte_ready_i = 1'b0;
        rst12 = 1'b0; flush12 = 1'b0; lv12 = 1'b0; d12 = '0; br12 = 1'b0;
        #12;
        check("rst_valid", 32'(byte_valid_o), 32'h0);
        check("rst_byte", 32'(byte_o), 32'h0);
        check("rst_idx", 32'(byte_idx_o), 32'h0);
        check("rst_last", 32'(byte_last_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        rst12 = 1'b1;

        // single read
        step(1'b1, 32'hA1B2C3D4, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        exp_bytes = 64'hD4C3B2A1;
        expect_log("single", exp_bytes, 4);

        // backpressure
        step(1'b1, 32'hA1B2C3D4, 1'b0, 1'b0);
        begin
            logic [9:0] pat;
            pat = 10'b0101100100;
            for (int i = 9; i >= 0; i--) step(1'b0, 32'h0, pat[i], 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        exp_bytes = 64'hD4C3B2A1;
        expect_log("bp", exp_bytes, 4);

        // back-to-back reload with no bubble
        step(1'b1, 32'h11223344, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h55667788, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        exp_bytes = 64'h4433221188776655;
        expect_log("b2b", exp_bytes, 8);

        // snapshot isolation
        step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        exp_bytes = 64'hEFBEADDE;
        expect_log("snap", exp_bytes, 4);

        // flush mid-stream, then restart at lane 0
        step(1'b1, 32'h01020304, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
        step(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        exp_bytes = 64'h04030DF0FECA;
        expect_log("flush", exp_bytes, 6);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) != 0, $urandom, ($urandom % 10) < 7, ($urandom % 32) == 0);
        end
        hs_log.delete();

        // partial top lane and async reset mid-stream
        @(negedge clk);
        lv12 = 1'b1; d12 = 12'hABC; br12 = 1'b1;
        @(negedge clk);
        lv12 = 1'b0; d12 = 12'h000;
        #1;
        check("p_valid0", 32'(bv12), 32'h1);
        check("p_byte0", 32'(b12), 32'hBC);
        check("p_idx0", 32'(idx12), 32'h0);
        check("p_last0", 32'(last12), 32'h0);
        @(negedge clk);
        br12 = 1'b0;
        #1;
        check("p_byte1", 32'(b12), 32'h0A);
        check("p_idx1", 32'(idx12), 32'h1);
        check("p_last1", 32'(last12), 32'h1);
        rst12 = 1'b0;
        #1;
        check("p_rst_valid", 32'(bv12), 32'h0);
        check("p_rst_byte", 32'(b12), 32'h0);
        check("p_rst_last", 32'(last12), 32'h0);
        @(negedge clk);
        rst12 = 1'b1;
        #1;
        check("p_ready", 32'(lr12), 32'h1);
        lv12 = 1'b1; d12 = 12'h5E7;
        @(negedge clk);
        lv12 = 1'b0;
        #1;
        check("p_restart_idx", 32'(idx12), 32'h0);
        check("p_restart_byte", 32'(b12), 32'hE7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_byte_reader.md
Name: register_byte_reader

Overview:
- Read-side counterpart of the byte-lane-writable register file in the TRNG datapath.
- Captures a WIDTH-bit register snapshot and streams it out one BYTE_WIDTH lane per handshake, LSB lane first, over a valid/ready byte interface.
- Feeds the byte-wide host/readout path; one snapshot is in flight at a time, with back-to-back reloads supported.

Parameters:
- WIDTH, 32, width of the register word being read.
- BYTE_WIDTH, 8, width of one output lane.
- NBYTES, (WIDTH-1)/BYTE_WIDTH+1, derived lane count; not overridden.
- IDX_W, max(1, clog2(NBYTES)), derived lane-index width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- flush_i  in  1  synchronous abort of the current snapshot.
- load_valid_i  in  1  snapshot request; d_i valid.
- load_ready_o  out  1  block can accept a snapshot.
- d_i  in  WIDTH  register word to read out.
- byte_valid_o  out  1  byte_o holds a valid lane.
- byte_ready_i  in  1  downstream accepts the lane.
- byte_o  out  BYTE_WIDTH  current lane.
- byte_idx_o  out  IDX_W  index of the current lane, 0..NBYTES-1.
- byte_last_o  out  1  current lane is lane NBYTES-1.

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE, shadow=0, idx=0.
  - byte_valid_o=0, byte_o=0, byte_idx_o=0, byte_last_o=0.
  - load_ready_o=1 as soon as rst is released.
- States: IDLE, SEND.
- Load handshake occurs when load_valid_i & load_ready_o.
  - d_i is copied into the internal shadow register.
  - idx=0, and the state moves to SEND on that edge.
  - The first byte is valid the next cycle: 1-cycle latency.
- In IDLE, load_ready_o=1.
- In SEND, load_ready_o = byte_ready_i & byte_last_o (combinational).
  - This allows a seamless reload on the final lane handshake.
- In SEND, byte_valid_o=1.
  - byte_o = shadow[idx*BYTE_WIDTH +: BYTE_WIDTH].
  - byte_idx_o = idx.
  - byte_last_o = (idx == NBYTES-1).
- Lane handshake (byte_valid_o & byte_ready_i):
  - Not last lane: idx increments.
  - Last lane with a simultaneous load handshake: new shadow captured, idx=0, stay in SEND.
  - Last lane without a load: go to IDLE, idx=0.
- Stall: while byte_ready_i=0, byte_o, byte_idx_o, byte_last_o and byte_valid_o are held stable. byte_valid_o never drops without a handshake, except on flush or reset.
- Partial top lane: when WIDTH is not a multiple of BYTE_WIDTH, the top lane is zero-padded in its upper bits.
- NBYTES=1: every handshake is the last lane; byte_last_o=1 throughout SEND.
- d_i is sampled only on the load handshake. Changes to d_i during SEND do not affect the bytes being output (snapshot semantics).
- flush_i=1 takes priority over everything except reset:
  - Next edge: state=IDLE, idx=0, byte_valid_o=0.
  - Any load or lane handshake in that cycle is ignored.
  - load_ready_o=0 while flush_i=1.
- rst asserted mid-stream: outputs go immediately to their reset values. There is no partial resume; the next snapshot starts at lane 0.
- byte_valid_o must never depend combinationally on byte_ready_i.

Test Plan:
1. Reset then single read: WIDTH=32, load d_i=0xA1B2C3D4, byte_ready_i=1 constantly.
   - Cycles 1-4 output bytes D4,C3,B2,A1 with idx 0,1,2,3.
   - byte_last_o=1 only on A1; IDLE with load_ready_o=1 after.
2. Backpressure: same load, byte_ready_i toggles 0,1,0,0,1,...
   - Each byte is held stable while ready=0.
   - Exactly 4 handshakes occur, in order D4,C3,B2,A1.
3. Back-to-back: load 0x11223344, then hold load_valid_i=1 with d_i=0x55667788.
   - Second load is accepted on the 0x11 handshake.
   - Stream is 44,33,22,11,88,77,66,55 with no bubble.
4. Snapshot isolation: load 0xDEADBEEF, then change d_i to 0 during SEND.
   - Output is still EF,BE,AD,DE.
5. Flush mid-stream: after 2 lanes, pulse flush_i with byte_ready_i=1.
   - byte_valid_o=0 next cycle; next load restarts at idx 0.
6. Partial lane plus async reset: WIDTH=12, load 0xABC.
   - Output is BC then 0A, byte_last_o on 0A.
   - Asserting rst between the two lanes immediately clears byte_valid_o and byte_o to 0.
